// File: rtl/wwd_pkg.sv
// Shared definitions for the window watchdog: FSM state encoding, fault
// status codes, fault-phase length and the window-counter load helper.
package wwd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FIRST_WIN  = 3'd1,
    ST_SECOND_WIN = 3'd2,
    ST_FAULT      = 3'd3,
    ST_LOCKED     = 3'd4
  } wwd_state_e;

  localparam logic [2:0] FL_NONE    = 3'b000;
  localparam logic [2:0] FL_EARLY   = 3'b001;
  localparam logic [2:0] FL_TIMEOUT = 3'b010;
  localparam logic [2:0] FL_LOCKED  = 3'b011;

  // Number of cycles the reset request stays asserted in FAULT.
  localparam int WD_RST_CYCLES = 4;

  // A window of len ticks loads len-1 and ends on the tick where it reads 0;
  // a zero length is treated as a single-tick window.
  function automatic logic [7:0] win_load(input logic [7:0] len);
    return (len == 8'd0) ? 8'd0 : len - 8'd1;
  endfunction

endpackage

// File: rtl/wwd_prescaler.sv
// Free-running tick prescaler: tick_o pulses once every PRESCALE cycles.
// clr_i restarts the count so a window always begins on a full period.
module wwd_prescaler #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  // Count up and wrap; a clear forces the count back to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/window_watchdog_ctrl.sv
// Window watchdog controller. A service must arrive in the open (second)
// window; servicing early or not at all raises a fault with a 4-cycle reset
// request, and too many faults lock the watchdog until RST_N.
// Optional build macro WWD_PRESCALE_EN: windows count prescaled ticks of
// PRESCALE cycles instead of raw clock cycles.
module window_watchdog_ctrl
  import wwd_pkg::*;
#(
  parameter int unsigned PRESCALE = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       INIT,
  input  logic       WDSRVC,
  input  logic [7:0] FWLEN,
  input  logic [7:0] SWLEN,
  input  logic [7:0] RST_LMT,
  output logic       WD_RST,
  output logic       SRVC_ACK,
  output logic [2:0] FLSTAT,
  output logic [7:0] FAIL_CNT,
  output logic [2:0] STATE
);

  wwd_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] fail_cnt_q, fail_cnt_d;
  logic [2:0] flstat_q, flstat_d;
  logic       srvc_ack_q, srvc_ack_d;
  logic       wdsrvc_q;
  logic       srvc_evt;
  logic       win_entry;
  logic       tick;
  wwd_state_e first_state;
  logic [7:0] first_load;
  logic [7:0] fail_inc;

`ifdef WWD_PRESCALE_EN
  wwd_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (win_entry),
    .tick_o (tick)
  );
`else
  logic unused_cfg;
  assign tick       = 1'b1;
  assign unused_cfg = win_entry ^ (^PRESCALE);
`endif

  assign srvc_evt    = WDSRVC && !wdsrvc_q;
  // An empty closed window means the open window starts straight away.
  assign first_state = (FWLEN == 8'd0) ? ST_SECOND_WIN : ST_FIRST_WIN;
  assign first_load  = (FWLEN == 8'd0) ? win_load(SWLEN) : win_load(FWLEN);
  assign fail_inc    = (fail_cnt_q == 8'hFF) ? fail_cnt_q : fail_cnt_q + 8'd1;

  assign WD_RST   = (state_q == ST_FAULT) || (state_q == ST_LOCKED);
  assign SRVC_ACK = srvc_ack_q;
  assign FLSTAT   = flstat_q;
  assign FAIL_CNT = fail_cnt_q;
  assign STATE    = state_q;

  // Next-state, window counter, fault bookkeeping and service acknowledge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fail_cnt_d = fail_cnt_q;
    flstat_d   = flstat_q;
    srvc_ack_d = 1'b0;
    win_entry  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (INIT) begin
          state_d   = first_state;
          cnt_d     = first_load;
          win_entry = 1'b1;
        end
      end
      ST_FIRST_WIN: begin
        if (!INIT) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (srvc_evt) begin
          state_d    = ST_FAULT;
          cnt_d      = 8'(WD_RST_CYCLES - 1);
          flstat_d   = FL_EARLY;
          fail_cnt_d = fail_inc;
        end else if (tick) begin
          if (cnt_q == 8'd0) begin
            state_d   = ST_SECOND_WIN;
            cnt_d     = win_load(SWLEN);
            win_entry = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_SECOND_WIN: begin
        if (!INIT) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (srvc_evt) begin
          state_d    = first_state;
          cnt_d      = first_load;
          win_entry  = 1'b1;
          flstat_d   = FL_NONE;
          srvc_ack_d = 1'b1;
        end else if (tick) begin
          if (cnt_q == 8'd0) begin
            state_d    = ST_FAULT;
            cnt_d      = 8'(WD_RST_CYCLES - 1);
            flstat_d   = FL_TIMEOUT;
            fail_cnt_d = fail_inc;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_FAULT: begin
        if (!INIT) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          if ((RST_LMT != 8'd0) && (fail_cnt_q >= RST_LMT)) begin
            state_d  = ST_LOCKED;
            flstat_d = FL_LOCKED;
          end else begin
            state_d   = first_state;
            cnt_d     = first_load;
            win_entry = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_LOCKED: begin
        state_d = ST_LOCKED;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and bookkeeping registers; reset aborts any window or fault.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      fail_cnt_q <= 8'd0;
      flstat_q   <= FL_NONE;
      srvc_ack_q <= 1'b0;
      wdsrvc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fail_cnt_q <= fail_cnt_d;
      flstat_q   <= flstat_d;
      srvc_ack_q <= srvc_ack_d;
      wdsrvc_q   <= WDSRVC;
    end
  end

endmodule

// File: tb/tb_window_watchdog_ctrl.sv
// Directed testbench for window_watchdog_ctrl. Inputs change and outputs are
// sampled on the falling clock edge; one line is printed per transaction.
module tb_window_watchdog_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FW   = 3'd1;
  localparam logic [2:0] S_SW   = 3'd2;
  localparam logic [2:0] S_FLT  = 3'd3;
  localparam logic [2:0] S_LCK  = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init = 1'b0;
  logic       wdsrvc = 1'b0;
  logic [7:0] fwlen = 8'd0;
  logic [7:0] swlen = 8'd0;
  logic [7:0] rst_lmt = 8'd0;
  logic       wd_rst;
  logic       srvc_ack;
  logic [2:0] flstat;
  logic [7:0] fail_cnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  window_watchdog_ctrl #(.PRESCALE(16)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .INIT     (init),
    .WDSRVC   (wdsrvc),
    .FWLEN    (fwlen),
    .SWLEN    (swlen),
    .RST_LMT  (rst_lmt),
    .WD_RST   (wd_rst),
    .SRVC_ACK (srvc_ack),
    .FLSTAT   (flstat),
    .FAIL_CNT (fail_cnt),
    .STATE    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    init = 1'b0;
    wdsrvc = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int hi;
    // Reset state
    rst_n = 1'b0;
    step();
    check("rst_state", state, S_IDLE);
    check("rst_wd_rst", wd_rst, 0);
    check("rst_ack", srvc_ack, 0);
    check("rst_flstat", flstat, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    rst_n = 1'b1;

`ifdef WWD_PRESCALE_EN
    // Prescaled first window: 2 ticks x 16 cycles
    fwlen = 8'd2; swlen = 8'd4; rst_lmt = 8'd0; init = 1'b1;
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (state == S_FW) hi++;
    end
    check("pre_fw_cycles", hi, 32);
`else
    // Valid service in second window cycle 2
    fwlen = 8'd3; swlen = 8'd4; rst_lmt = 8'd0; init = 1'b1;
    step();
    check("s1_fw_c1", state, S_FW);
    step(); step();
    check("s1_fw_c3", state, S_FW);
    step();
    check("s1_sw_c1", state, S_SW);
    step();
    wdsrvc = 1'b1;
    step();
    check("s1_ack", srvc_ack, 1);
    check("s1_refw", state, S_FW);
    check("s1_flstat", flstat, 0);
    wdsrvc = 1'b0;
    step();
    check("s1_ack_drop", srvc_ack, 0);

    // Early service in first window cycle 2
    do_reset();
    fwlen = 8'd5; init = 1'b1;
    step(); step();
    wdsrvc = 1'b1;
    step();
    wdsrvc = 1'b0;
    check("s2_fault", state, S_FLT);
    check("s2_flstat", flstat, 1);
    check("s2_fail_cnt", fail_cnt, 1);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (wd_rst) hi++;
      step();
    end
    check("s2_wd_rst_len", hi, 4);
    check("s2_back_fw", state, S_FW);

    // Timeout, then a second timeout locks
    do_reset();
    fwlen = 8'd1; swlen = 8'd2; rst_lmt = 8'd2; init = 1'b1;
    step();
    check("s3_fw", state, S_FW);
    step(); step();
    check("s3_sw_c2", state, S_SW);
    step();
    check("s3_fault", state, S_FLT);
    check("s3_flstat", flstat, 2);
    check("s3_fail_cnt", fail_cnt, 1);
    repeat (11) step();
    check("s4_locked", state, S_LCK);
    check("s4_flstat", flstat, 3);
    check("s4_fail_cnt", fail_cnt, 2);
    init = 1'b0; wdsrvc = 1'b1;
    step(); step();
    wdsrvc = 1'b0;
    step();
    check("s4_still_locked", state, S_LCK);
    check("s4_wd_rst", wd_rst, 1);
    rst_n = 1'b0;
    #1;
    check("s4_async_state", state, S_IDLE);
    check("s4_async_wd_rst", wd_rst, 0);
    check("s4_async_fail", fail_cnt, 0);
    step();
    rst_n = 1'b1;

    // Service ignored in IDLE
    wdsrvc = 1'b1;
    step();
    wdsrvc = 1'b0;
    step();
    check("s5_idle_ign", state, S_IDLE);
    check("s5_idle_ack", srvc_ack, 0);

    // Zero-length windows, then INIT drop mid-fault
    fwlen = 8'd0; swlen = 8'd0; rst_lmt = 8'd0; init = 1'b1;
    step();
    check("s6_skip_fw", state, S_SW);
    wdsrvc = 1'b1;
    step();
    wdsrvc = 1'b0;
    check("s6_ack", srvc_ack, 1);
    check("s6_sw_again", state, S_SW);
    step();
    check("s6_timeout", state, S_FLT);
    check("s6_flstat", flstat, 2);
    init = 1'b0;
    step();
    check("s6_idle", state, S_IDLE);
    check("s6_wd_rst", wd_rst, 0);
    check("s6_keep_fail", fail_cnt, 1);
    check("s6_keep_flstat", flstat, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_watchdog_ctrl.md
WINDOW_WATCHDOG_CTRL -- requirements
Module: window_watchdog_ctrl

Interface
REQ-001 Parameter: PRESCALE, 16, CLK cycles per window tick; used only when WWD_PRESCALE_EN is defined.
REQ-002 CLK  in  1  single clock; all state on rising edge.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 INIT  in  1  watchdog enable level from configuration register.
REQ-005 WDSRVC  in  1  service request level; rising edge = one service event.
REQ-006 FWLEN  in  8  closed (first) window length in ticks.
REQ-007 SWLEN  in  8  open (second) window length in ticks.
REQ-008 RST_LMT  in  8  fault count that locks the watchdog; 0 = never lock.
REQ-009 WD_RST  out  1  system reset request, active-high.
REQ-010 SRVC_ACK  out  1  one-cycle pulse on a valid service.
REQ-011 FLSTAT  out  3  last fault: 000 none, 001 early service, 010 timeout, 011 locked.
REQ-012 FAIL_CNT  out  8  accumulated faults, saturating at 255.
REQ-013 STATE  out  3  current FSM state encoding.

Function
REQ-014 States SHALL be IDLE, FIRST_WIN, SECOND_WIN, FAULT, LOCKED.
REQ-015 Service event SHALL be WDSRVC high with WDSRVC registered low the previous cycle; 1-cycle detection latency.
REQ-016 IDLE: INIT high SHALL go to FIRST_WIN next cycle, loading the window counter from FWLEN.
REQ-017 Window counter SHALL load len-1, decrement once per tick, and end the window on the tick where it equals 0; FWLEN=3, no prescaler -> FIRST_WIN lasts exactly 3 cycles.
REQ-018 FWLEN=0 SHALL skip FIRST_WIN (enter SECOND_WIN next cycle); SWLEN=0 SHALL behave as 1.
REQ-019 FWLEN/SWLEN SHALL be sampled only at window entry; mid-window changes take effect at the next entry.
REQ-020 Service in FIRST_WIN, including its final cycle, SHALL enter FAULT with FLSTAT=001.
REQ-021 Service in SECOND_WIN, including its final cycle, SHALL pulse SRVC_ACK, set FLSTAT=000 and re-enter FIRST_WIN.
REQ-022 SECOND_WIN expiry without service SHALL enter FAULT with FLSTAT=010.
REQ-023 FAULT entry SHALL increment FAIL_CNT (saturating); WD_RST SHALL be high for exactly WD_RST_CYCLES=4 cycles in FAULT.
REQ-024 FAULT exit SHALL go to LOCKED if RST_LMT!=0 and FAIL_CNT>=RST_LMT, else FIRST_WIN.
REQ-025 LOCKED SHALL hold WD_RST high and FLSTAT=011, ignore all inputs, and exit only via RST_N.
REQ-026 INIT low SHALL force IDLE from FIRST_WIN/SECOND_WIN/FAULT next cycle, drop WD_RST, and retain FAIL_CNT and FLSTAT.
REQ-027 Service events in IDLE, FAULT and LOCKED SHALL be ignored.

Reset
REQ-028 RST_N low SHALL immediately force IDLE, WD_RST=0, SRVC_ACK=0, FLSTAT=000, FAIL_CNT=0, counters and prescaler 0, edge register 0.
REQ-029 Reset mid-window or mid-FAULT SHALL abort with no pending ACK or fault.

Configuration
REQ-030 Macro WWD_PRESCALE_EN defined: a tick SHALL occur once every PRESCALE cycles from a free-running prescaler, cleared on window entry.
REQ-031 Macro undefined: every CLK cycle SHALL be a tick and no prescaler logic SHALL exist.

Structure
REQ-032 Package wwd_pkg SHALL hold state encoding, FLSTAT codes and WD_RST_CYCLES.
REQ-033 Sub-module wwd_prescaler SHALL generate the tick (instantiated only under WWD_PRESCALE_EN).

Verification
REQ-034 FWLEN=3, SWLEN=4, INIT=1, service on SECOND_WIN cycle 2 -> SRVC_ACK one cycle, FLSTAT=000, FIRST_WIN re-entered.
REQ-035 FWLEN=5, service on FIRST_WIN cycle 2 -> FAULT, FLSTAT=001, WD_RST high 4 cycles, FAIL_CNT=1.
REQ-036 SWLEN=2, no service -> FAULT after 2 SECOND_WIN cycles, FLSTAT=010.
REQ-037 RST_LMT=2, two timeouts -> LOCKED, WD_RST stays high, FLSTAT=011 until RST_N pulse.
REQ-038 FWLEN=0, SWLEN=0, service on first SECOND_WIN cycle -> accepted; INIT drop mid-FAULT -> IDLE, WD_RST=0.
REQ-039 WWD_PRESCALE_EN, PRESCALE=16, FWLEN=2 -> FIRST_WIN lasts 32 cycles.
